// File: rtl/pipelined_multiplier_hs.sv
// Purpose : pipelined WIDTHxWIDTH multiplier, per-op signed/unsigned mode, opaque tag carried with each op.
// Latency : STAGES cycles; an op accepted at edge k is on the output after edge k+STAGES-1, plus one per stalled cycle.
// Backpr. : the whole pipe (bubbles included) freezes while out_valid && !out_ready; in_ready drops in the same cycle.
//
// Ports:
//   clk, reset       rising-edge clock, synchronous active-low reset
//   in_valid/ready   operand handshake (a, b, is_signed, in_tag)
//   out_valid/ready  result handshake (product, out_tag)
//   inflight         ops accepted but not yet delivered (0..STAGES)

module pipelined_multiplier_hs #(
   parameter int WIDTH  = 8,
   parameter int STAGES = 3,
   parameter int TAG_W  = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [WIDTH-1:0]              a,
   input  logic [WIDTH-1:0]              b,
   input  logic                          is_signed,
   input  logic [TAG_W-1:0]              in_tag,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [2*WIDTH-1:0]            product,
   output logic [TAG_W-1:0]              out_tag,
   output logic [$clog2(STAGES+2)-1:0]   inflight
);

   localparam int  PW    = 2 * WIDTH;
   localparam int  CW    = $clog2(STAGES + 2);
   // With two or more stages the multiply is split: stage 0 holds two partial
   // products, stage 1 adds them. A single stage has to do it all at once.
   localparam bit  SPLIT = (STAGES > 1);

   logic              adv;
   logic              acc;
   logic              dlv;

   logic [PW-1:0]     a_ext;
   logic [PW-1:0]     b_ext;
   logic [PW-1:0]     pp_lo;
   logic [WIDTH-1:0]  pp_hi;
   logic [PW-1:0]     prod_full;
   logic [PW-1:0]     merged;

   logic              vld_q  [STAGES];
   logic              vld_d  [STAGES];
   logic [TAG_W-1:0]  tag_q  [STAGES];
   logic [TAG_W-1:0]  tag_d  [STAGES];
   logic [PW-1:0]     prod_q [STAGES];
   logic [PW-1:0]     prod_d [STAGES];
   logic [WIDTH-1:0]  hi_q;
   logic [WIDTH-1:0]  hi_d;
   logic [CW-1:0]     inflight_q;
   logic [CW-1:0]     inflight_d;

   // ------------------------------------------------------------------
   // Handshake
   // ------------------------------------------------------------------
   assign out_valid = vld_q[STAGES-1];
   assign product   = prod_q[STAGES-1];
   assign out_tag   = tag_q[STAGES-1];
   assign inflight  = inflight_q;

   assign adv      = !out_valid || out_ready;
   assign in_ready = reset && adv;
   assign acc      = in_valid && in_ready;
   assign dlv      = out_valid && out_ready;

   // ------------------------------------------------------------------
   // Arithmetic
   // Both operands are extended to 2*WIDTH so one modular multiply covers
   // signed and unsigned. b_ext is split into halves:
   //   a_ext*b_ext mod 2^PW = a_ext*lo + ((a_ext*hi) mod 2^WIDTH) << WIDTH
   // and the second term only needs the low WIDTH bits of a_ext.
   // ------------------------------------------------------------------
   assign a_ext = is_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
   assign b_ext = is_signed ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};

   assign pp_lo     = a_ext * {{WIDTH{1'b0}}, b_ext[WIDTH-1:0]};
   assign pp_hi     = a_ext[WIDTH-1:0] * b_ext[PW-1:WIDTH];
   assign prod_full = pp_lo + {pp_hi, {WIDTH{1'b0}}};

   // Second half of the split multiply, feeding stage 1.
   assign merged = prod_q[0] + {hi_q, {WIDTH{1'b0}}};

   // ------------------------------------------------------------------
   // Next state
   // ------------------------------------------------------------------
   always_comb begin
      for (int s = 0; s < STAGES; s++) begin
         vld_d[s]  = vld_q[s];
         tag_d[s]  = tag_q[s];
         prod_d[s] = prod_q[s];
      end
      hi_d = hi_q;

      if (adv) begin
         // Stage 0 takes the new op or a bubble; data only loads on accept.
         vld_d[0] = acc;
         if (acc) begin
            tag_d[0]  = in_tag;
            prod_d[0] = SPLIT ? pp_lo : prod_full;
            hi_d      = pp_hi;
         end
         for (int s = 1; s < STAGES; s++) begin
            vld_d[s]  = vld_q[s-1];
            tag_d[s]  = tag_q[s-1];
            prod_d[s] = (s == 1) ? merged : prod_q[s-1];
         end
      end

      unique case ({acc, dlv})
         2'b10:   inflight_d = inflight_q + CW'(1);
         2'b01:   inflight_d = inflight_q - CW'(1);
         default: inflight_d = inflight_q;
      endcase
   end

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int s = 0; s < STAGES; s++) begin
            vld_q[s]  <= 1'b0;
            tag_q[s]  <= '0;
            prod_q[s] <= '0;
         end
         hi_q       <= '0;
         inflight_q <= '0;
      end else begin
         for (int s = 0; s < STAGES; s++) begin
            vld_q[s]  <= vld_d[s];
            tag_q[s]  <= tag_d[s];
            prod_q[s] <= prod_d[s];
         end
         hi_q       <= hi_d;
         inflight_q <= inflight_d;
      end
   end

endmodule

// File: tb/tb_pipelined_multiplier_hs.sv
// Purpose : self-checking bench for pipelined_multiplier_hs at STAGES = 1, 3 and 5 (WIDTH=8, TAG_W=4).
// Latency : a scoreboard tracks, per op, how many unstalled edges remain before it must appear.
// Backpr. : out_ready is driven per instance (directed stalls on the STAGES=3 copy, random on all).

module tb_pipelined_multiplier_hs;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        in_valid;
   logic [7:0]  a;
   logic [7:0]  b;
   logic        is_signed;
   logic [3:0]  in_tag;
   logic        or_r [3];

   logic        ir1, ov1, ir3, ov3, ir5, ov5;
   logic [15:0] prod1, prod3, prod5;
   logic [3:0]  tag1, tag3, tag5;
   logic [1:0]  inf1;
   logic [2:0]  inf3, inf5;

   int tests = 0;
   int fails = 0;

   pipelined_multiplier_hs #(.WIDTH(8), .STAGES(1), .TAG_W(4)) u_s1 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir1), .a(a), .b(b),
      .is_signed(is_signed), .in_tag(in_tag), .out_valid(ov1), .out_ready(or_r[0]),
      .product(prod1), .out_tag(tag1), .inflight(inf1));

   pipelined_multiplier_hs #(.WIDTH(8), .STAGES(3), .TAG_W(4)) u_s3 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir3), .a(a), .b(b),
      .is_signed(is_signed), .in_tag(in_tag), .out_valid(ov3), .out_ready(or_r[1]),
      .product(prod3), .out_tag(tag3), .inflight(inf3));

   pipelined_multiplier_hs #(.WIDTH(8), .STAGES(5), .TAG_W(4)) u_s5 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir5), .a(a), .b(b),
      .is_signed(is_signed), .in_tag(in_tag), .out_valid(ov5), .out_ready(or_r[2]),
      .product(prod5), .out_tag(tag5), .inflight(inf5));

   logic        ir  [3];
   logic        ov  [3];
   logic [15:0] pr  [3];
   logic [3:0]  tg  [3];
   logic [2:0]  inf [3];

   always_comb begin
      ir[0] = ir1;  ir[1] = ir3;  ir[2] = ir5;
      ov[0] = ov1;  ov[1] = ov3;  ov[2] = ov5;
      pr[0] = prod1; pr[1] = prod3; pr[2] = prod5;
      tg[0] = tag1; tg[1] = tag3; tg[2] = tag5;
      inf[0] = {1'b0, inf1}; inf[1] = inf3; inf[2] = inf5;
   end

   // ------------------------------------------------------------------
   // Reference arithmetic and scoreboard
   // ------------------------------------------------------------------
   function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y, input logic s);
      int xi, yi, p;
      xi = s ? int'($signed(x)) : int'(x);
      yi = s ? int'($signed(y)) : int'(y);
      p  = xi * yi;
      return p[15:0];
   endfunction

   function automatic int stages_of(input int i);
      return (i == 0) ? 1 : ((i == 1) ? 3 : 5);
   endfunction

   typedef struct packed {
      logic [15:0] p;
      logic [3:0]  t;
      int          rem;   // unstalled edges left before this op must be on the output
   } op_t;

   op_t  mq [3][8];
   int   mh [3] = '{0, 0, 0};
   int   mc [3] = '{0, 0, 0};
   logic m_exp_ov;
   logic m_adv;
   int   m_idx;

   // Inputs change just after posedge; the negedge sees exactly what the next edge will see.
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (!reset) begin
            tests++;
            if (ir[i] !== 1'b0) begin
               fails++;
               $display("FAIL s%0d in_ready_in_reset: got %b want 0", stages_of(i), ir[i]);
            end
            mh[i] = 0;
            mc[i] = 0;
         end else begin
            m_exp_ov = (mc[i] > 0) && (mq[i][mh[i]].rem == 0);
            tests++;
            if (ov[i] !== m_exp_ov) begin
               fails++;
               $display("FAIL s%0d out_valid @%0t: got %b want %b", stages_of(i), $time, ov[i], m_exp_ov);
            end
            if (m_exp_ov) begin
               tests++;
               if (pr[i] !== mq[i][mh[i]].p || tg[i] !== mq[i][mh[i]].t) begin
                  fails++;
                  $display("FAIL s%0d result @%0t: got %h/tag %h want %h/tag %h", stages_of(i), $time,
                           pr[i], tg[i], mq[i][mh[i]].p, mq[i][mh[i]].t);
               end
            end
            tests++;
            if (inf[i] !== 3'(mc[i])) begin
               fails++;
               $display("FAIL s%0d inflight @%0t: got %0d want %0d", stages_of(i), $time, inf[i], mc[i]);
            end
            m_adv = !m_exp_ov || or_r[i];
            tests++;
            if (ir[i] !== m_adv) begin
               fails++;
               $display("FAIL s%0d in_ready @%0t: got %b want %b", stages_of(i), $time, ir[i], m_adv);
            end
            if (m_exp_ov && or_r[i]) begin
               mh[i] = (mh[i] + 1) % 8;
               mc[i] = mc[i] - 1;
            end
            if (m_adv) begin
               for (int j = 0; j < mc[i]; j++) begin
                  m_idx = (mh[i] + j) % 8;
                  if (mq[i][m_idx].rem > 0) mq[i][m_idx].rem = mq[i][m_idx].rem - 1;
               end
               if (in_valid) begin
                  m_idx = (mh[i] + mc[i]) % 8;
                  mq[i][m_idx].p   = ref_mul(a, b, is_signed);
                  mq[i][m_idx].t   = in_tag;
                  mq[i][m_idx].rem = stages_of(i) - 1;
                  mc[i] = mc[i] + 1;
               end
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [7:0] x, input logic [7:0] y, input logic s, input logic [3:0] t);
      in_valid  = 1'b1;
      a         = x;
      b         = y;
      is_signed = s;
      in_tag    = t;
   endtask

   // ------------------------------------------------------------------
   // Scenarios (directed ones observe the STAGES=3 instance)
   // ------------------------------------------------------------------
   task automatic test_reset();
      reset = 1'b0;
      in_valid = 1'b0; a = '0; b = '0; is_signed = 1'b0; in_tag = '0;
      for (int i = 0; i < 3; i++) or_r[i] = 1'b1;
      tick();
      tick();
      tests++; if (ov3  !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", ov3); end
      tests++; if (prod3 !== 16'h0) begin fails++; $display("FAIL reset_product: got %h want 0000", prod3); end
      tests++; if (inf3 !== 3'd0) begin fails++; $display("FAIL reset_inflight: got %0d want 0", inf3); end
      tests++; if (ir3  !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b want 0", ir3); end
      reset = 1'b1;
      #1;
      tests++; if (ir3 !== 1'b1) begin fails++; $display("FAIL release_in_ready: got %b want 1", ir3); end
   endtask

   task automatic test_unsigned();
      logic [7:0]  xa [2];
      logic [7:0]  xb [2];
      logic [15:0] xp [2];
      int          j;
      xa[0] = 8'd15;  xb[0] = 8'd10;  xp[0] = 16'h0096;
      xa[1] = 8'd255; xb[1] = 8'd255; xp[1] = 16'hFE01;
      for (int c = 0; c < 6; c++) begin
         if (c < 2) drive(xa[c], xb[c], 1'b0, 4'(c + 1));
         else       in_valid = 1'b0;
         tick();
         j = c - 2;   // op accepted at edge c must be visible right after edge c+2
         if (j >= 0 && j < 2) begin
            tests++;
            if (ov3 !== 1'b1 || prod3 !== xp[j] || tag3 !== 4'(j + 1)) begin
               fails++;
               $display("FAIL unsigned_op%0d: got v=%b p=%h t=%h want v=1 p=%h t=%h", j, ov3, prod3, tag3, xp[j], 4'(j + 1));
            end
         end else begin
            tests++;
            if (ov3 !== 1'b0) begin fails++; $display("FAIL unsigned_idle c%0d: got v=%b want 0", c, ov3); end
         end
      end
   endtask

   task automatic test_signed();
      logic [7:0]  xa [4];
      logic [7:0]  xb [4];
      logic        xs [4];
      logic [15:0] xp [4];
      int          j;
      xa[0] = 8'hFF; xb[0] = 8'h01; xs[0] = 1'b1; xp[0] = 16'hFFFF;
      xa[1] = 8'h80; xb[1] = 8'h80; xs[1] = 1'b1; xp[1] = 16'h4000;
      xa[2] = 8'h80; xb[2] = 8'h7F; xs[2] = 1'b1; xp[2] = 16'hC080;
      xa[3] = 8'hFF; xb[3] = 8'h01; xs[3] = 1'b0; xp[3] = 16'h00FF;
      for (int c = 0; c < 8; c++) begin
         if (c < 4) drive(xa[c], xb[c], xs[c], 4'(c + 3));
         else       in_valid = 1'b0;
         tick();
         j = c - 2;
         if (j >= 0 && j < 4) begin
            tests++;
            if (ov3 !== 1'b1 || prod3 !== xp[j] || tag3 !== 4'(j + 3)) begin
               fails++;
               $display("FAIL signed_op%0d: got v=%b p=%h t=%h want v=1 p=%h t=%h", j, ov3, prod3, tag3, xp[j], 4'(j + 3));
            end
         end else begin
            tests++;
            if (ov3 !== 1'b0) begin fails++; $display("FAIL signed_idle c%0d: got v=%b want 0", c, ov3); end
         end
      end
   endtask

   task automatic test_backpressure();
      logic [7:0]  xa [6];
      logic [7:0]  xb [6];
      logic        xs [6];
      logic [15:0] xp [6];
      logic [15:0] held_p;
      logic [3:0]  held_t;
      logic        was_stall;
      int          sent, recv, peak;
      sent = 0; recv = 0; peak = 0; was_stall = 1'b0;
      held_p = '0; held_t = '0;
      for (int k = 0; k < 6; k++) begin
         xa[k] = 8'($urandom);
         xb[k] = 8'($urandom);
         xs[k] = 1'($urandom);
         xp[k] = ref_mul(xa[k], xb[k], xs[k]);
      end
      for (int cyc = 0; cyc < 40 && recv < 6; cyc++) begin
         or_r[1] = !(cyc >= 4 && cyc < 8);
         if (sent < 6) drive(xa[sent], xb[sent], xs[sent], 4'(sent));
         else          in_valid = 1'b0;
         #1;
         if (ov3 && !or_r[1]) begin
            tests++;
            if (ir3 !== 1'b0) begin fails++; $display("FAIL bp_in_ready_stall c%0d: got %b want 0", cyc, ir3); end
            if (was_stall) begin
               tests++;
               if (prod3 !== held_p || tag3 !== held_t) begin
                  fails++;
                  $display("FAIL bp_hold c%0d: got %h/%h want %h/%h", cyc, prod3, tag3, held_p, held_t);
               end
            end
            held_p = prod3;
            held_t = tag3;
            was_stall = 1'b1;
         end else begin
            was_stall = 1'b0;
         end
         if (int'(inf3) > peak) peak = int'(inf3);
         if (ov3 && or_r[1]) begin
            tests++;
            if (prod3 !== xp[recv] || tag3 !== 4'(recv)) begin
               fails++;
               $display("FAIL bp_result%0d: got %h/%h want %h/%h", recv, prod3, tag3, xp[recv], 4'(recv));
            end
            recv++;
         end
         if (in_valid && ir3) sent++;
         tick();
      end
      in_valid = 1'b0;
      or_r[1] = 1'b1;
      tests++; if (recv != 6) begin fails++; $display("FAIL bp_count: got %0d results want 6", recv); end
      tests++; if (peak != 3) begin fails++; $display("FAIL bp_inflight_peak: got %0d want 3", peak); end
   endtask

   task automatic test_reset_midflight();
      drive(8'd7, 8'd9, 1'b0, 4'hA);
      tick();
      drive(8'd3, 8'd4, 1'b0, 4'hB);
      tick();
      in_valid = 1'b0;
      reset = 1'b0;
      tick();
      tests++; if (ov3 !== 1'b0) begin fails++; $display("FAIL rst_mid_out_valid: got %b want 0", ov3); end
      tests++; if (inf3 !== 3'd0) begin fails++; $display("FAIL rst_mid_inflight: got %0d want 0", inf3); end
      reset = 1'b1;
      for (int c = 0; c < 6; c++) begin
         tick();
         tests++;
         if (ov3 !== 1'b0) begin fails++; $display("FAIL rst_mid_ghost c%0d: got v=%b want 0", c, ov3); end
      end
      drive(8'hFD, 8'd5, 1'b1, 4'h9);   // -3 * 5
      #1;
      tests++; if (ir3 !== 1'b1) begin fails++; $display("FAIL rst_mid_ready: got %b want 1", ir3); end
      tick();
      in_valid = 1'b0;
      tick();
      tests++; if (ov3 !== 1'b0) begin fails++; $display("FAIL rst_mid_early: got v=%b want 0", ov3); end
      tick();
      tests++;
      if (ov3 !== 1'b1 || prod3 !== 16'hFFF1 || tag3 !== 4'h9) begin
         fails++;
         $display("FAIL rst_mid_new_op: got v=%b p=%h t=%h want v=1 p=fff1 t=9", ov3, prod3, tag3);
      end
      tick();
      tests++; if (ov3 !== 1'b0) begin fails++; $display("FAIL rst_mid_after: got v=%b want 0", ov3); end
   endtask

   task automatic test_random();
      for (int cyc = 0; cyc < 800; cyc++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         a         = ($urandom_range(0, 7) == 0) ? 8'h80 : 8'($urandom);
         b         = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
         is_signed = 1'($urandom);
         in_tag    = 4'($urandom);
         for (int i = 0; i < 3; i++) or_r[i] = ($urandom_range(0, 3) != 0);
         tick();
      end
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) or_r[i] = 1'b1;
      for (int c = 0; c < 10; c++) tick();
      for (int i = 0; i < 3; i++) begin
         tests++;
         if (ov[i] !== 1'b0 || inf[i] !== 3'd0) begin
            fails++;
            $display("FAIL rand_drain s%0d: got v=%b inflight=%0d want 0/0", stages_of(i), ov[i], inf[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_signed();
      test_backpressure();
      test_reset_midflight();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
